// File: rtl/operand_loader_pkg.sv
// rtl/operand_loader_pkg.sv - shared definitions for the operand loader
//
// Purpose: default operand width and hold window, FSM state encoding and
// operand slot indices shared by operand_loader and its sub-module.
// Ports: none (package).

package operand_loader_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  localparam logic [1:0] IDX_A = 2'd0;
  localparam logic [1:0] IDX_B = 2'd1;
  localparam logic [1:0] IDX_C = 2'd2;
  localparam logic [1:0] IDX_D = 2'd3;

endpackage

// File: rtl/operand_loader_hold_timer.sv
// rtl/operand_loader_hold_timer.sv - hold window down-counter
//
// Purpose: counts down the remaining cycles of the out_valid hold window.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   flush       synchronous clear of the count
//   load        load value into the count (a new set is presented)
//   value       reload value (HOLD_CYCLES-1)
//   expired     count has reached zero

module hold_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          expired
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - stages four operands and presents them as one set
//
// Purpose: collects A, B, C, D words from a valid/ready stream into a staging
// buffer and transfers a complete set atomically into the A..D registers that
// feed the operator block, holding them for at least HOLD_CYCLES cycles.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               synchronous abort of staging and presentation
//   in_data/in_valid    operand word stream in
//   in_ready            staging buffer can accept a word
//   A, B, C, D          registered operands
//   out_valid           A..D hold a complete, stable set
//   out_ready           downstream has sampled the results
//   sets_done           completed-set counter, wraps at 255

module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       sets_done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [WIDTH-1:0] stage [4];
  logic [1:0]       idx;
  logic             stage_full;
  state_t           state_q, state_d;
  logic             expired;
  logic             accept;
  logic             completion;
  logic             transfer;

  assign in_ready   = !stage_full;
  assign accept     = in_valid && in_ready && !flush;
  assign completion = (state_q == PRESENT) && expired && out_ready;
  // Transfer may coincide with completion, which gives the back-to-back case
  // where out_valid never drops and A..D are replaced in place.
  assign transfer   = stage_full && ((state_q == IDLE) || completion);

  // Staging buffer. accept and transfer are mutually exclusive because
  // accept needs stage_full low and transfer needs it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        stage[i] <= '0;
      end
      idx        <= '0;
      stage_full <= 1'b0;
    end else if (flush) begin
      idx        <= '0;
      stage_full <= 1'b0;
    end else if (transfer) begin
      stage_full <= 1'b0;
    end else if (accept) begin
      stage[idx] <= in_data;
      idx        <= idx + 2'd1;
      if (idx == IDX_D) begin
        stage_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == PRESENT);
    if (flush) begin
      state_d = IDLE;
    end else if (transfer) begin
      state_d = PRESENT;
    end else if (completion) begin
      state_d = IDLE;
    end
  end

  // A..D and sets_done survive a flush; only the staging/FSM state aborts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      sets_done <= '0;
    end else if (!flush) begin
      if (transfer) begin
        A <= stage[IDX_A];
        B <= stage[IDX_B];
        C <= stage[IDX_C];
        D <= stage[IDX_D];
      end
      if (completion) begin
        sets_done <= sets_done + 8'd1;
      end
    end
  end

  hold_timer #(
    .CW(CW)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .load   (transfer && !flush),
    .value  (CW'(HOLD_CYCLES - 1)),
    .expired(expired)
  );

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - directed self-checking bench for operand_loader

module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] A, B, C, D;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sets_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  operand_loader #(
    .WIDTH(4),
    .HOLD_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .C        (C),
    .D        (D),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sets_done(sets_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_abcd(input string tag, input logic [15:0] expv);
    check(tag, {16'd0, A, B, C, D}, {16'd0, expv});
  endtask

  // Present a word and return at the negedge after its handshake edge.
  task automatic send_word(input logic [3:0] w);
    int waited;
    waited   = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next clock edge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_abcd"}, {16'd0, A, B, C, D}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_sets_done"}, {24'd0, sets_done}, 32'd0);
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic count_valid(output int n);
    n = 0;
    while (out_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_abcd", {16'd0, A, B, C, D}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sets_done", {24'd0, sets_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single set with a free output path.
    out_ready = 1'b1;
    send_word(4'b1100);
    send_word(4'b0110);
    send_word(4'b0011);
    send_word(4'b1100);
    in_valid = 1'b0;
    check("single_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("single_out_valid_early", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("single_in_ready_back", {31'd0, in_ready}, 32'd1);
    check_abcd("single_abcd", 16'b1100_0110_0011_1100);
    count_valid(cnt);
    check("single_valid_len", cnt, 32'd4);
    check("single_sets_done", {24'd0, sets_done}, 32'd1);

    // Stall: out_ready low holds the set indefinitely.
    out_ready = 1'b0;
    send_word(4'b1010);
    send_word(4'b0101);
    send_word(4'b1001);
    send_word(4'b0110);
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_abcd("stall_abcd", 16'b1010_0101_1001_0110);
      @(negedge clk);
    end
    check("stall_sets_before", {24'd0, sets_done}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_out_valid_fall", {31'd0, out_valid}, 32'd0);
    check("stall_sets_done", {24'd0, sets_done}, 32'd2);
    @(negedge clk);
    check("stall_sets_once", {24'd0, sets_done}, 32'd2);

    mid_reset("midrst");

    // Back-to-back: second set staged during PRESENT of the first.
    out_ready = 1'b0;
    send_word(4'b1100);
    send_word(4'b0110);
    send_word(4'b0011);
    send_word(4'b1100);
    send_word(4'b0001);
    send_word(4'b0010);
    send_word(4'b0100);
    send_word(4'b1000);
    in_valid = 1'b0;
    check("b2b_first_valid", {31'd0, out_valid}, 32'd1);
    check_abcd("b2b_first_abcd", 16'b1100_0110_0011_1100);
    check("b2b_stage_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b_valid_kept", {31'd0, out_valid}, 32'd1);
    check_abcd("b2b_second_abcd", 16'b0001_0010_0100_1000);
    check("b2b_sets_mid", {24'd0, sets_done}, 32'd1);
    count_valid(cnt);
    check("b2b_second_len", cnt, 32'd4);
    check("b2b_sets_done", {24'd0, sets_done}, 32'd2);

    // Flush after two words; the dropped partial set must not leak.
    out_ready = 1'b1;
    send_word(4'b1110);
    send_word(4'b0111);
    in_data  = 4'b1011;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    send_word(4'b1111);
    send_word(4'b0000);
    send_word(4'b1010);
    send_word(4'b0101);
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", {31'd0, out_valid}, 32'd1);
    check_abcd("flush_abcd", 16'b1111_0000_1010_0101);
    count_valid(cnt);
    check("flush_sets_done", {24'd0, sets_done}, 32'd3);

    // Wrap: 256 sets from reset bring sets_done back to 0.
    mid_reset("wraprst");
    out_ready = 1'b1;
    for (int j = 0; j < 1020; j++) begin
      send_word(j[3:0]);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("wrap_sets_255", {24'd0, sets_done}, 32'd255);
    check_abcd("wrap_abcd_255", 16'h89ab);
    for (int j = 1020; j < 1024; j++) begin
      send_word(j[3:0]);
    end
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    check("wrap_sets_0", {24'd0, sets_done}, 32'd0);
    check_abcd("wrap_abcd_256", 16'hcdef);
    check("wrap_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
